// File: rtl/ps2_joypad_pkg.sv
// ps2_joypad_pkg: scancodes, button bit indices, receiver states and key-map helpers.
package ps2_joypad_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_REL    = 8'hF0;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_A      = 8'h29;
  localparam logic [7:0] SC_B      = 8'h11;
  localparam logic [7:0] SC_SELECT = 8'h0D;
  localparam logic [7:0] SC_START  = 8'h76;
  localparam logic [7:0] SC_START2 = 8'h5A;
  localparam logic [7:0] SC_PAD1   = 8'h16;
  localparam logic [7:0] SC_PAD2   = 8'h1E;
  localparam logic [7:0] SC_PAD3   = 8'h26;
  localparam logic [7:0] SC_PAD4   = 8'h25;
  localparam logic [7:0] PP_CODES [12] = '{8'h24, 8'h2D, 8'h2C, 8'h35, 8'h23, 8'h2B,
                                          8'h34, 8'h33, 8'h21, 8'h2A, 8'h32, 8'h31};
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  function automatic logic [7:0] btn_mask(input logic [7:0] sc);
    logic [7:0] m;
    m = '0;
    case (sc)
      SC_A:               m[BTN_A]      = 1'b1;
      SC_B:               m[BTN_B]      = 1'b1;
      SC_SELECT:          m[BTN_SELECT] = 1'b1;
      SC_START, SC_START2: m[BTN_START] = 1'b1;
      SC_UP:              m[BTN_UP]     = 1'b1;
      SC_DOWN:            m[BTN_DOWN]   = 1'b1;
      SC_LEFT:            m[BTN_LEFT]   = 1'b1;
      SC_RIGHT:           m[BTN_RIGHT]  = 1'b1;
      default:            m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [11:0] pp_mask(input logic [7:0] sc);
    logic [11:0] m;
    m = '0;
    for (int i = 0; i < 12; i++) m[i] = (sc == PP_CODES[i]);
    return m;
  endfunction

  // {hit, index} for the pad-select digit keys
  function automatic logic [2:0] pad_key(input logic [7:0] sc);
    return sc == SC_PAD1 ? 3'b100 : sc == SC_PAD2 ? 3'b101 :
           sc == SC_PAD3 ? 3'b110 : sc == SC_PAD4 ? 3'b111 : 3'b000;
  endfunction
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 line synchroniser, glitch filter and frame receiver with timeout.
module ps2_rx
  import ps2_joypad_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       err_o
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [1:0] csync_q, dsync_q, filt_q, samp;
  logic [FW-1:0] fcnt_q [2];
  logic fclk_prev_q, fall, din;
  rx_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  assign samp   = {dsync_q[1], csync_q[1]};
  assign fall   = fclk_prev_q & ~filt_q[0];
  assign din    = filt_q[1];
  assign byte_o = sr_q;
  // A filtered line flips only on the FILTER_LEN-th consecutive differing sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csync_q     <= '1;
      dsync_q     <= '1;
      filt_q      <= '1;
      fcnt_q      <= '{default: '0};
      fclk_prev_q <= 1'b1;
    end else begin
      csync_q     <= {csync_q[0], ps2_clk_i};
      dsync_q     <= {dsync_q[0], ps2_data_i};
      fclk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (samp[i] == filt_q[i]) fcnt_q[i] <= '0;
        else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
          filt_q[i] <= samp[i];
          fcnt_q[i] <= '0;
        end else fcnt_q[i] <= fcnt_q[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    par_d      = par_q;
    tmo_d      = (state_q == IDLE || fall) ? '0 : tmo_q + 1'b1;
    byte_vld_o = 1'b0;
    err_o      = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: if (!din) begin
          state_d = DATA;
          cnt_d   = '0;
        end
        DATA: begin
          sr_d    = {din, sr_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          state_d = cnt_q == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = ^{sr_q, din};
          state_d = STOP;
        end
        STOP: begin
          byte_vld_o = din & par_q;
          err_o      = ~(din & par_q);
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = IDLE;
      err_o   = 1'b1;
    end
  end
endmodule

// File: rtl/ps2_joypad_decoder.sv
// ps2_joypad_decoder: PS/2 scancodes to joypad/Power Pad buttons; PS2_ERRCNT_EN enables err_count.
module ps2_joypad_decoder
  import ps2_joypad_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ps2_kbd_clk,
  input  logic                  ps2_kbd_data,
  output logic [NUM_PADS*8-1:0] joystick,
  output logic [11:0]           powerpad,
  output logic [1:0]            pad_sel,
  output logic                  code_valid,
  output logic [8:0]            code_out,
  output logic                  code_release,
  output logic [7:0]            err_count
);
  logic [7:0] rx_byte, bm, btn_q, btn_d;
  logic rx_vld, rx_err;
  logic [11:0] pm, pp_q, pp_d;
  logic [2:0] pk;
  logic ext_q, ext_d, rel_q, rel_d, vld_q, vld_d, crel_q, crel_d;
  logic [1:0] sel_q, sel_d;
  logic [8:0] code_q, code_d;
  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk_i (ps2_kbd_clk),
    .ps2_data_i(ps2_kbd_data),
    .byte_o    (rx_byte),
    .byte_vld_o(rx_vld),
    .err_o     (rx_err)
  );
  assign bm = btn_mask(rx_byte);
  assign pm = pp_mask(rx_byte);
  assign pk = pad_key(rx_byte);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_q  <= 1'b0;
      rel_q  <= 1'b0;
      btn_q  <= '0;
      pp_q   <= '0;
      sel_q  <= '0;
      code_q <= '0;
      crel_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      ext_q  <= ext_d;
      rel_q  <= rel_d;
      btn_q  <= btn_d;
      pp_q   <= pp_d;
      sel_q  <= sel_d;
      code_q <= code_d;
      crel_q <= crel_d;
      vld_q  <= vld_d;
    end
  end
  always_comb begin
    ext_d  = ext_q;
    rel_d  = rel_q;
    btn_d  = btn_q;
    pp_d   = pp_q;
    sel_d  = sel_q;
    code_d = code_q;
    crel_d = crel_q;
    vld_d  = 1'b0;
    if (rx_vld) begin
      if (rx_byte == SC_EXT) ext_d = 1'b1;
      else if (rx_byte == SC_REL) rel_d = 1'b1;
      else begin
        vld_d  = 1'b1;
        code_d = {ext_q, rx_byte};
        crel_d = rel_q;
        ext_d  = 1'b0;
        rel_d  = 1'b0;
        btn_d  = rel_q ? btn_q & ~bm : btn_q | bm;
        pp_d   = rel_q ? pp_q & ~pm : pp_q | pm;
        if (pk[2] && !rel_q && {30'd0, pk[1:0]} < NUM_PADS) sel_d = pk[1:0];
      end
    end
  end
  // One button register, shown only on the selected pad
  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    assign joystick[8*g +: 8] = sel_q == 2'(g) ? btn_q : 8'h00;
  end
  assign powerpad     = pp_q;
  assign pad_sel      = sel_q;
  assign code_valid   = vld_q;
  assign code_out     = code_q;
  assign code_release = crel_q;
`ifdef PS2_ERRCNT_EN
  logic [7:0] err_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= '0;
    else if (rx_err && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end
  assign err_count = err_q;
`else
  logic unused_err;
  assign unused_err = rx_err;
  assign err_count  = '0;
`endif
endmodule

// File: tb/tb_ps2_joypad_decoder.sv
// tb_ps2_joypad_decoder: table-driven scancode vectors plus error, timeout, glitch and reset sequences.
module tb_ps2_joypad_decoder;
  localparam int NUM_PADS = 2;
  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT_CYC = 300;
  localparam int HALF = 8;
`ifdef PS2_ERRCNT_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, kclk = 1'b1, kdat = 1'b1;
  logic [15:0] joystick;
  logic [11:0] powerpad;
  logic [1:0] pad_sel;
  logic code_valid, code_release;
  logic [8:0] code_out;
  logic [7:0] err_count;
  int checks = 0, errors = 0, vcnt = 0, v0;

  ps2_joypad_decoder #(.NUM_PADS(NUM_PADS), .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_kbd_clk(kclk), .ps2_kbd_data(kdat),
    .joystick(joystick), .powerpad(powerpad), .pad_sel(pad_sel), .code_valid(code_valid),
    .code_out(code_out), .code_release(code_release), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (code_valid === 1'b1) vcnt <= vcnt + 1;

  typedef struct {
    logic [7:0]  sc;
    logic [15:0] joy;
    logic [11:0] pp;
    logic [1:0]  sel;
    int          nv;
    logic [8:0]  code;
    logic        rel;
  } vec_t;
  vec_t tv[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad);
    return {1'b1, (~^b) ^ bad, b, 1'b0};
  endfunction

  task automatic ps2_bit(input logic b);
    kdat = b;
    repeat (HALF) @(negedge clk);
    kclk = 1'b0;
    repeat (HALF) @(negedge clk);
    kclk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) ps2_bit(bits[i]);
    kdat = 1'b1;
    repeat (3 * HALF) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{8'h29, 16'h0001, 12'h000, 2'd0, 1, 9'h029, 1'b0};
    tv[1]  = '{8'hF0, 16'h0001, 12'h000, 2'd0, 0, 9'h029, 1'b0};
    tv[2]  = '{8'h29, 16'h0000, 12'h000, 2'd0, 1, 9'h029, 1'b1};
    tv[3]  = '{8'h1E, 16'h0000, 12'h000, 2'd1, 1, 9'h01E, 1'b0};
    tv[4]  = '{8'hE0, 16'h0000, 12'h000, 2'd1, 0, 9'h01E, 1'b0};
    tv[5]  = '{8'h75, 16'h1000, 12'h000, 2'd1, 1, 9'h175, 1'b0};
    tv[6]  = '{8'h26, 16'h1000, 12'h000, 2'd1, 1, 9'h026, 1'b0};
    tv[7]  = '{8'h16, 16'h0010, 12'h000, 2'd0, 1, 9'h016, 1'b0};
    tv[8]  = '{8'h5A, 16'h0018, 12'h000, 2'd0, 1, 9'h05A, 1'b0};
    tv[9]  = '{8'h76, 16'h0018, 12'h000, 2'd0, 1, 9'h076, 1'b0};
    tv[10] = '{8'hF0, 16'h0018, 12'h000, 2'd0, 0, 9'h076, 1'b0};
    tv[11] = '{8'h76, 16'h0010, 12'h000, 2'd0, 1, 9'h076, 1'b1};
    tv[12] = '{8'h24, 16'h0010, 12'h001, 2'd0, 1, 9'h024, 1'b0};
    tv[13] = '{8'h31, 16'h0010, 12'h801, 2'd0, 1, 9'h031, 1'b0};
    tv[14] = '{8'hE0, 16'h0010, 12'h801, 2'd0, 0, 9'h031, 1'b0};
    tv[15] = '{8'hF0, 16'h0010, 12'h801, 2'd0, 0, 9'h031, 1'b0};
    tv[16] = '{8'h75, 16'h0000, 12'h801, 2'd0, 1, 9'h175, 1'b1};
    tv[17] = '{8'h44, 16'h0000, 12'h801, 2'd0, 1, 9'h044, 1'b0};
    tv[18] = '{8'hF0, 16'h0000, 12'h801, 2'd0, 0, 9'h044, 1'b0};
    tv[19] = '{8'h24, 16'h0000, 12'h800, 2'd0, 1, 9'h024, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset joystick", 32'(joystick), 0);
    chk("reset powerpad", 32'(powerpad), 0);
    chk("reset pad_sel", 32'(pad_sel), 0);
    chk("reset code_out", 32'(code_out), 0);
    chk("reset valid", 32'(code_valid), 0);
    chk("reset err", 32'(err_count), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      v0 = vcnt;
      send_bits(frame(tv[i].sc, 1'b0), 11);
      chk($sformatf("row%0d joystick", i), 32'(joystick), 32'(tv[i].joy));
      chk($sformatf("row%0d powerpad", i), 32'(powerpad), 32'(tv[i].pp));
      chk($sformatf("row%0d pad_sel", i), 32'(pad_sel), 32'(tv[i].sel));
      chk($sformatf("row%0d valid_count", i), 32'(vcnt - v0), 32'(tv[i].nv));
      chk($sformatf("row%0d code_out", i), 32'(code_out), 32'(tv[i].code));
      chk($sformatf("row%0d release", i), 32'(code_release), 32'(tv[i].rel));
    end

    v0 = vcnt;
    send_bits(frame(8'h29, 1'b1), 11);
    chk("parity valid_count", 32'(vcnt - v0), 0);
    chk("parity err", 32'(err_count), 32'(ERR_ON));
    chk("parity joystick", 32'(joystick), 0);
    chk("parity code_out", 32'(code_out), 32'h024);

    send_bits(frame(8'h24, 1'b0), 5);
    repeat (TIMEOUT_CYC + 40) @(negedge clk);
    chk("timeout err", 32'(err_count), 32'(2 * ERR_ON));
    v0 = vcnt;
    send_bits(frame(8'h24, 1'b0), 11);
    chk("post-timeout valid_count", 32'(vcnt - v0), 1);
    chk("post-timeout powerpad", 32'(powerpad), 32'h801);

    kdat = 1'b0;
    repeat (2) @(negedge clk);
    kclk = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clk);
    kclk = 1'b1;
    repeat (10) @(negedge clk);
    kdat = 1'b1;
    repeat (10) @(negedge clk);
    v0 = vcnt;
    send_bits(frame(8'h29, 1'b0), 11);
    chk("glitch valid_count", 32'(vcnt - v0), 1);
    chk("glitch code_out", 32'(code_out), 32'h029);
    chk("glitch joystick", 32'(joystick), 32'h0001);
    chk("glitch err", 32'(err_count), 32'(2 * ERR_ON));

    send_bits(frame(8'h11, 1'b0), 4);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset joystick", 32'(joystick), 0);
    chk("async reset powerpad", 32'(powerpad), 0);
    chk("async reset code_out", 32'(code_out), 0);
    chk("async reset err", 32'(err_count), 0);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post reset err", 32'(err_count), 0);
    chk("post reset valid", 32'(code_valid), 0);
    v0 = vcnt;
    send_bits(frame(8'h29, 1'b0), 11);
    chk("after reset valid_count", 32'(vcnt - v0), 1);
    chk("after reset joystick", 32'(joystick), 32'h0001);
    chk("after reset code_out", 32'(code_out), 32'h029);
    chk("after reset err", 32'(err_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_joypad_decoder.md
PS2_JOYPAD_DECODER -- requirements
Module: ps2_joypad_decoder

Interface
REQ-001 Parameter NUM_PADS, default 2: number of joystick channels, legal 1..4.
REQ-002 Parameter FILTER_LEN, default 4: PS/2 clock/data glitch-filter depth in clk samples, legal 2..8.
REQ-003 Parameter TIMEOUT_CYC, default 20000: clk cycles without a PS/2 clock falling edge before a partial frame is aborted.
REQ-004 clk  in  1  system clock; all logic SHALL be clocked on its rising edge only.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ps2_kbd_clk, ps2_kbd_data  in  1 each  raw asynchronous PS/2 lines.
REQ-007 joystick  out  NUM_PADS*8  packed pad buttons, pad p at [8p+7:8p]; bit 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
REQ-008 powerpad  out  12  Power Pad button state.
REQ-009 pad_sel  out  2  currently routed pad index.
REQ-010 code_valid  out  1  one-cycle strobe per complete non-prefix scancode.
REQ-011 code_out  out  9  {ext, code} of last scancode; code_release  out  1  release flag of last scancode.
REQ-012 err_count  out  8  saturating frame-error counter.

Function
REQ-013 Each PS/2 line SHALL pass a 2-flop synchroniser, then a filter that changes the filtered level only after FILTER_LEN identical consecutive samples.
REQ-014 Receiver FSM SHALL have states IDLE, DATA, PARITY, STOP, sampling ps2 data on filtered-clock falling edges.
REQ-015 IDLE: falling edge with data 0 -> DATA (bit count cleared); data 1 -> remain IDLE, no error.
REQ-016 DATA: 8 bits, LSB first, then -> PARITY; PARITY: odd parity over data+parity checked, -> STOP.
REQ-017 STOP: stop bit 1 and parity good -> frame accepted; otherwise frame discarded and err_count incremented; either way -> IDLE.
REQ-018 In any non-IDLE state, TIMEOUT_CYC cycles without a falling edge SHALL force IDLE and increment err_count.
REQ-019 err_count SHALL saturate at 255 and never wrap.
REQ-020 Accepted 0xE0 SHALL set ext flag; 0xF0 SHALL set rel flag; neither produces code_valid.
REQ-021 Other accepted byte SHALL, one clk after the stop-bit edge, pulse code_valid, load code_out={ext,byte}, code_release=rel, update joystick/powerpad in that same cycle, and clear ext and rel.
REQ-022 Key map (ext ignored): 75/72/6B/74 -> Up/Down/Left/Right; 29 A; 11 B; 0D Select; 76 and 5A Start; Power Pad bits 0..11 = 24,2D,2C,35,23,2B,34,33,21,2A,32,31.
REQ-023 Press sets, release clears the mapped bit; unmapped codes change no button state.
REQ-024 Keys 16,1E,26,25 (digits 1..4) press SHALL set pad_sel to 0..3 only if index < NUM_PADS; releases and out-of-range digits ignored.
REQ-025 A single 8-bit button register SHALL be driven onto pad pad_sel; all other pads read 0; a pad switch moves held buttons to the new pad.
REQ-026 Start mapped from two keys: release of either clears bit 3.

Reset
REQ-027 reset_n low SHALL asynchronously clear FSM to IDLE, ext, rel, filters (to idle-high), buttons, powerpad, pad_sel, code_out, code_release, code_valid, err_count, timeout counter.
REQ-028 Reset mid-frame SHALL discard the partial frame without error count; the first frame after release decodes normally.

Configuration
REQ-029 Macro PS2_ERRCNT_EN defined: err_count per REQ-017..019; undefined: err_count tied to 0, counter logic absent, frame discard unchanged.

Structure
REQ-030 Package ps2_joypad_pkg SHALL hold scancode constants, button bit-index constants and the receiver FSM state enum.
REQ-031 Sub-module ps2_rx (synchroniser, filter, FSM, timeout) SHALL output a byte strobe plus error strobe; the top holds prefix and key-map logic.

Verification
REQ-032 Frame 0x29 sent -> code_valid once, code_out=0x029, joystick[0]=1; then F0 29 -> joystick[0]=0, code_release=1.
REQ-033 E0 75 with NUM_PADS=2, key 2 pressed first -> pad_sel=1, joystick[12]=1, joystick[7:0]=0, code_out=0x175.
REQ-034 Frame with wrong parity for 0x29 -> no code_valid, err_count=1, buttons unchanged.
REQ-035 Send start + 4 bits then stop toggling for TIMEOUT_CYC cycles -> FSM IDLE, err_count +1; next full 0x24 frame -> powerpad[0]=1.
REQ-036 Glitch of FILTER_LEN-1 cycles on ps2_kbd_clk -> no bit sampled; reset_n pulsed mid-frame -> all outputs 0, err_count 0.
